ikaopll_pg_vib: RTL
===================

# ikaopll_pg_vib

Phase generator front end that consumes the LFO's vibrato (`PMVAL`) and tremolo (`AMVAL`) values. It applies them to the 18 time-multiplexed operator slots. Per slot it modulates F-number by the vibrato step and scales it by block and MUL. It accumulates a 19-bit phase and forwards the tremolo attenuation for AM-enabled slots. It sits between the register file, the LFO and the operator/envelope pipeline.

## Interface
- No parameters; slot count (18) and widths are package constants.
- `i_EMUCLK` in 1: emulator master clock; all state updates on posedge.
- `i_RST` in 1: synchronous, active-high reset.
- `i_phi1_NCEN_n` in 1: clock enable, active low; all state advances only when low ("tick").
- `i_CYCLE_00` in 1: marks slot 0 at stage-0 input; forces the slot counter to 0.
- `i_TEST` in 4: test register; bit 2 = phase reset (all slots).
- `i_PMVAL` in 3: vibrato step index from the LFO.
- `i_AMVAL` in 4: tremolo attenuation from the LFO.
- `i_FNUM` in 9: F-number of the current input slot.
- `i_BLOCK` in 3: octave of the current input slot.
- `i_MUL` in 4: multiplier code of the current input slot.
- `i_PM_EN` in 1: vibrato enable for the current slot.
- `i_AM_EN` in 1: tremolo enable for the current slot.
- `i_PHASE_RST` in 1: key-on phase reset for the current slot.
- `o_SLOT` out 5: slot index of the outputs (0..17).
- `o_PHASE` out 10: phase[18:9] of the output slot.
- `o_AMATT` out 4: tremolo attenuation for the output slot (0 when AM disabled).

## Operation
- Slot counter: 5 bits, increments each tick and wraps 17→0. `i_CYCLE_00` loads 0 and takes priority over increment.
- Stage 1, vibrato:
  - `full = FNUM[8:6]`, `half = FNUM[8:7]`.
  - Delta by PMVAL 0..7 is 0, +half, +full, +half, 0, −half, −full, −half.
  - `fmod = FNUM + delta` is 10 bits unsigned. Underflow is impossible because delta ≤ FNUM; maximum is 511+7=518.
  - When `PM_EN=0`, delta = 0.
- Stage 2, scaling:
  - `fb = (fmod << BLOCK) >> 1`, 16 bits.
  - MUL×2 table: 1,2,4,6,8,10,12,14,16,18,20,20,24,24,30,30.
  - `inc = (fb * mul2) >> 1`, 20 bits.
- Stage 3, accumulate:
  - The phase store is an 18-entry × 19-bit circular shift register, one entry per slot.
  - New = (old + inc) mod 2^19.
  - If the slot's `PHASE_RST` (carried down the pipe) or `i_TEST[2]` is set, new = 0 and the increment is discarded.
- AM path: `AM_EN ? i_AMVAL : 0` is delayed alongside the phase pipe. AMVAL is sampled at stage 1.
- Reset: the slot counter, all pipe registers and all 18 phase entries clear to 0 over the reset ticks. The phase store requires ≥18 reset ticks to fully clear. Reset is applied by forcing the shift-in value to 0.

## Timing
- Latency: 3 ticks from slot inputs to `o_PHASE`/`o_AMATT`. `o_SLOT` = input slot − 3 mod 18.
- Outputs are registered and change only on ticks. They hold between ticks when `i_phi1_NCEN_n` is high.
- Reset values: `o_PHASE` = 0, `o_AMATT` = 0, `o_SLOT` = 0.
- Phase of slot k updates once per 18-tick frame; the stored value is read and written in the same tick.
- Simultaneous `PHASE_RST` and `TEST[2]`: result is 0.
- `i_CYCLE_00` arriving mid-frame re-aligns the counter immediately. The pipe contents are not flushed; the phase store shifts unconditionally.
- Reset mid-frame: takes effect on the next tick regardless of `i_CYCLE_00`.

## Structure
- Shared package `ikaopll_pkg`: `SLOT_NUM=18`, `PHASE_W=19`, `PHASE_OUT_W=10`, the MUL×2 table function, and the vibrato delta function.
- One sub-module: `ikaopll_pg_sr` holds the 18×19 circular phase store with zero-load input.
- The rest is pipeline logic in the top module.

## Test plan
- Reset: hold `i_RST` 18 ticks, then release with all slot inputs 0 → `o_PHASE=0` and `o_AMATT=0` for all 18 slots for ≥2 frames.
- Plain accumulate: slot 0 only, FNUM=256, BLOCK=4, MUL=1, PM_EN=0 → inc=2048, so slot 0 `o_PHASE` advances by 4 each frame. The 19-bit accumulator wraps to 0 after 256 frames.
- Vibrato: FNUM=448, PM_EN=1 → fmod = 448, 451, 455, 451, 448, 445, 441, 445 for PMVAL 0..7. The same input with PM_EN=0 → 448 constant.
- MUL codes: sweep MUL 0..15 with FNUM=256, BLOCK=1 (fb=256). inc = 256 × mul2 / 2, e.g. MUL=0 → 128, MUL=15 → 3840; inc for MUL 10 equals MUL 11.
- Phase reset: pulse `i_PHASE_RST` for slot 5 only → slot 5 `o_PHASE=0` three ticks later while other slots keep counting. `i_TEST[2]`=1 for one frame → all slots read 0.
- AM and slot alignment: AMVAL=9, AM_EN=1 on odd slots only → `o_AMATT` = 9, 0 alternating with `o_SLOT` lagging the input by 3. A mid-frame `i_CYCLE_00` → the counter restarts at 0 on that tick.

Source files
------------

// File: rtl/ikaopll_pkg.sv
// ikaopll_pkg: shared constants, pipe bundles and
// lookup helpers for the phase generator front end.
package ikaopll_pkg;

  localparam int SLOT_NUM    = 18;
  localparam int SLOT_W      = 5;
  localparam int PHASE_W     = 19;
  localparam int PHASE_OUT_W = 10;
  localparam int FNUM_W      = 9;
  localparam int FMOD_W      = 10;
  localparam int FB_W        = 16;
  localparam int INC_W       = 20;
  localparam int AM_W        = 4;

  localparam logic [SLOT_W-1:0] SLOT_LAST =
    SLOT_W'(SLOT_NUM - 1);

  // vibrato stage -> scaling stage
  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic [FMOD_W-1:0] fmod;
    logic [2:0]        block;
    logic [3:0]        mul;
    logic              prst;
    logic [AM_W-1:0]   am;
  } vib_scl_t;

  // scaling stage -> accumulate stage
  typedef struct packed {
    logic [SLOT_W-1:0] slot;
    logic [INC_W-1:0]  inc;
    logic              prst;
    logic [AM_W-1:0]   am;
  } scl_acc_t;

  // twice the frequency multiplier, so MUL=0 (x0.5)
  // stays an integer
  function automatic logic [4:0] mul2(
    input logic [3:0] mul
  );
    logic [4:0] r;
    r = 5'd1;
    case (mul)
      4'd0:  r = 5'd1;
      4'd1:  r = 5'd2;
      4'd2:  r = 5'd4;
      4'd3:  r = 5'd6;
      4'd4:  r = 5'd8;
      4'd5:  r = 5'd10;
      4'd6:  r = 5'd12;
      4'd7:  r = 5'd14;
      4'd8:  r = 5'd16;
      4'd9:  r = 5'd18;
      4'd10: r = 5'd20;
      4'd11: r = 5'd20;
      4'd12: r = 5'd24;
      4'd13: r = 5'd24;
      4'd14: r = 5'd30;
      4'd15: r = 5'd30;
      default: r = 5'd1;
    endcase
    return r;
  endfunction

  // F-number bent by the LFO vibrato step; the
  // subtracted term is always <= fnum, so no wrap
  function automatic logic [FMOD_W-1:0] vib_fmod(
    input logic [FNUM_W-1:0] fnum,
    input logic [2:0]        pmval,
    input logic              pm_en
  );
    logic [FMOD_W-1:0] base;
    logic [FMOD_W-1:0] full;
    logic [FMOD_W-1:0] half;
    logic [FMOD_W-1:0] r;
    base = {1'b0, fnum};
    full = {7'd0, fnum[8:6]};
    half = {8'd0, fnum[8:7]};
    r    = base;
    if (pm_en) begin
      case (pmval)
        3'd1, 3'd3: r = base + half;
        3'd2:       r = base + full;
        3'd5, 3'd7: r = base - half;
        3'd6:       r = base - full;
        default:    r = base;
      endcase
    end
    return r;
  endfunction

endpackage

// File: rtl/ikaopll_pg_sr.sv
// ikaopll_pg_sr: 18-entry circular phase store, one
// entry per slot, shifting on every tick.
// Ports: i_EMUCLK clock, i_CEN tick enable,
// i_ZERO forces a zero shift-in, i_D shift-in value,
// o_Q oldest entry (stored phase of the slot now
// entering the accumulate stage).
module ikaopll_pg_sr
  import ikaopll_pkg::*;
(
  input  logic               i_EMUCLK,
  input  logic               i_CEN,
  input  logic               i_ZERO,
  input  logic [PHASE_W-1:0] i_D,
  output logic [PHASE_W-1:0] o_Q
);

  logic [PHASE_W-1:0] mem [SLOT_NUM];

  // no reset on the array: holding i_ZERO for a full
  // rotation clears every entry
  always_ff @(posedge i_EMUCLK) begin
    if (i_CEN) begin
      mem[0] <= i_ZERO ? '0 : i_D;
      for (int i = 1; i < SLOT_NUM; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign o_Q = mem[SLOT_NUM-1];

endmodule

// File: rtl/ikaopll_pg_vib.sv
// ikaopll_pg_vib: phase generator front end. Applies
// LFO vibrato to F-number, scales by block and MUL,
// accumulates a 19-bit phase per slot and forwards
// tremolo attenuation for AM-enabled slots.
// Inputs: i_EMUCLK, i_RST (sync, high), i_phi1_NCEN_n
// (tick when low), i_CYCLE_00 (slot 0 marker),
// i_TEST[2] phase reset, i_PMVAL, i_AMVAL, and the
// per-slot i_FNUM/i_BLOCK/i_MUL/i_PM_EN/i_AM_EN/
// i_PHASE_RST.
// Outputs (3 ticks behind inputs): o_SLOT, o_PHASE
// (phase[18:9]), o_AMATT.
module ikaopll_pg_vib
  import ikaopll_pkg::*;
(
  input  logic                   i_EMUCLK,
  input  logic                   i_RST,
  input  logic                   i_phi1_NCEN_n,
  input  logic                   i_CYCLE_00,
  input  logic [3:0]             i_TEST,
  input  logic [2:0]             i_PMVAL,
  input  logic [AM_W-1:0]        i_AMVAL,
  input  logic [FNUM_W-1:0]      i_FNUM,
  input  logic [2:0]             i_BLOCK,
  input  logic [3:0]             i_MUL,
  input  logic                   i_PM_EN,
  input  logic                   i_AM_EN,
  input  logic                   i_PHASE_RST,
  output logic [SLOT_W-1:0]      o_SLOT,
  output logic [PHASE_OUT_W-1:0] o_PHASE,
  output logic [AM_W-1:0]        o_AMATT
);

  logic tick;
  assign tick = ~i_phi1_NCEN_n;

  logic unused_test;
  assign unused_test = ^{i_TEST[3], i_TEST[1:0]};

  vib_scl_t s1;
  vib_scl_t s1_d;
  scl_acc_t s2;
  scl_acc_t s2_d;

  logic [SLOT_W-1:0] slot_nxt;

  // s1.slot doubles as the slot counter
  always_comb begin
    slot_nxt = s1.slot + 1'b1;
    if (i_CYCLE_00 || s1.slot == SLOT_LAST) begin
      slot_nxt = '0;
    end
  end

  // stage 1: vibrato and AM gating
  always_comb begin
    s1_d       = '0;
    s1_d.slot  = slot_nxt;
    s1_d.fmod  = vib_fmod(i_FNUM, i_PMVAL, i_PM_EN);
    s1_d.block = i_BLOCK;
    s1_d.mul   = i_MUL;
    s1_d.prst  = i_PHASE_RST;
    s1_d.am    = i_AM_EN ? i_AMVAL : '0;
  end

  // stage 2: block shift then multiplier
  logic [FB_W:0]    fb_shl;
  logic [FB_W-1:0]  fb;
  logic [INC_W:0]   inc_x2;

  always_comb begin
    fb_shl = {{(FB_W+1-FMOD_W){1'b0}}, s1.fmod}
             << s1.block;
    fb     = FB_W'(fb_shl >> 1);
    inc_x2 = (INC_W+1)'(fb) *
             (INC_W+1)'(mul2(s1.mul));
    s2_d      = '0;
    s2_d.slot = s1.slot;
    s2_d.inc  = INC_W'(inc_x2 >> 1);
    s2_d.prst = s1.prst;
    s2_d.am   = s1.am;
  end

  // stage 3: read-modify-write of the phase store
  logic [PHASE_W-1:0] phase_old;
  logic [PHASE_W-1:0] phase_new;

  always_comb begin
    phase_new = phase_old + PHASE_W'(s2.inc);
    if (s2.prst || i_TEST[2]) begin
      phase_new = '0;
    end
  end

  ikaopll_pg_sr u_sr (
    .i_EMUCLK (i_EMUCLK),
    .i_CEN    (tick),
    .i_ZERO   (i_RST),
    .i_D      (phase_new),
    .o_Q      (phase_old)
  );

  always_ff @(posedge i_EMUCLK) begin
    if (tick) begin
      if (i_RST) begin
        s1      <= '0;
        s2      <= '0;
        o_SLOT  <= '0;
        o_PHASE <= '0;
        o_AMATT <= '0;
      end else begin
        s1      <= s1_d;
        s2      <= s2_d;
        o_SLOT  <= s2.slot;
        o_PHASE <= phase_new[PHASE_W-1 -: PHASE_OUT_W];
        o_AMATT <= s2.am;
      end
    end
  end

endmodule
